// File: rtl/store_queue_if.sv
// Store queue port bundle: issue side, CDB snoop, flush control and the
// head-of-queue request toward the ROB/memory bus.
interface store_queue_if #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 5,
    parameter int ADDR_W = 23
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                      flush;
    logic                      keep_en;
    logic [TAG_W-1:0]          keep_tag;
    logic                      issue;
    logic [TAG_W-1:0]          issue_tag;
    logic [15:0]               immed_in;
    logic [31:0]               Vj_in;
    logic [TAG_W-1:0]          Qj_in;
    logic [31:0]               Vstore_in;
    logic [TAG_W-1:0]          Qstore_in;
    logic                      cdb_en;
    logic [TAG_W-1:0]          cdb_tag;
    logic [31:0]               cdb_data;
    logic                      bus_granted;
    logic                      full;
    logic [CNT_W-1:0]          count;
    logic                      req_bus;
    logic [TAG_W+ADDR_W:0]     addr_out;
    logic [32+TAG_W+31:0]      data_out;

    modport master (
        output flush, keep_en, keep_tag, issue, issue_tag, immed_in,
               Vj_in, Qj_in, Vstore_in, Qstore_in,
               cdb_en, cdb_tag, cdb_data, bus_granted,
        input  full, count, req_bus, addr_out, data_out
    );

    modport slave (
        input  flush, keep_en, keep_tag, issue, issue_tag, immed_in,
               Vj_in, Qj_in, Vstore_in, Qstore_in,
               cdb_en, cdb_tag, cdb_data, bus_granted,
        output full, count, req_bus, addr_out, data_out
    );
endinterface

// File: rtl/store_queue.sv
// In-order store queue: circular FIFO of pending stores that snoop the CDB
// for their base/data operands and leave strictly from the head once both
// are ready. A flush can truncate the queue just after a kept entry.
module store_queue #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 5,
    parameter int ADDR_W = 23
) (
    input  logic          clk,
    input  logic          rst,
    store_queue_if.slave  sq
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [PTR_W-1:0] head_next, tail_next;
    logic [PTR_W-1:0] count_int;
    logic [IDX_W-1:0] head_idx, tail_idx;

    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0][TAG_W-1:0]  tag_arr, qj_arr, qs_arr;
    logic [DEPTH-1:0][31:0]       vj_arr, vs_arr;
    logic [DEPTH-1:0][15:0]       imm_arr;

    logic             full_int, nonempty, req_int;
    logic             pop, issue_acc;
    logic             byp_j, byp_s;
    logic             keep_hit;
    logic [PTR_W-1:0] keep_off;
    logic [31:0]      head_addr;
    logic             unused_addr;

    assign head_idx  = head_reg[IDX_W-1:0];
    assign tail_idx  = tail_reg[IDX_W-1:0];
    assign count_int = tail_reg - head_reg;
    assign full_int  = (count_int == PTR_W'(DEPTH));
    assign nonempty  = (count_int != '0);

    // Head may only leave once both of its operands have been resolved.
    assign req_int   = nonempty && (qj_arr[head_idx] == '0) && (qs_arr[head_idx] == '0);
    assign pop       = sq.bus_granted && req_int;
    assign issue_acc = sq.issue && !full_int && !sq.flush;

    // An operand produced on the CDB in the issue cycle is taken directly.
    assign byp_j = sq.cdb_en && (sq.Qj_in != '0) && (sq.Qj_in == sq.cdb_tag);
    assign byp_s = sq.cdb_en && (sq.Qstore_in != '0) && (sq.Qstore_in == sq.cdb_tag);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [IDX_W-1:0] off;
            logic             wr, hit_j, hit_s;
            logic [TAG_W-1:0] tag_reg, qj_reg, qs_reg;
            logic [31:0]      vj_reg, vs_reg;
            logic [15:0]      imm_reg;

            // Position relative to head decides whether this slot is live.
            assign off              = IDX_W'(gi) - head_idx;
            assign entry_valid[gi]  = ({1'b0, off} < count_int);
            assign wr               = issue_acc && (tail_idx == IDX_W'(gi));
            assign hit_j            = entry_valid[gi] && sq.cdb_en &&
                                      (qj_reg != '0) && (qj_reg == sq.cdb_tag);
            assign hit_s            = entry_valid[gi] && sq.cdb_en &&
                                      (qs_reg != '0) && (qs_reg == sq.cdb_tag);

            // Operand tags: set on issue, cleared when the producer broadcasts.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    qj_reg <= '0;
                    qs_reg <= '0;
                end else if (wr) begin
                    qj_reg <= byp_j ? '0 : sq.Qj_in;
                    qs_reg <= byp_s ? '0 : sq.Qstore_in;
                end else begin
                    if (hit_j) qj_reg <= '0;
                    if (hit_s) qs_reg <= '0;
                end
            end

            // Payload: captured on issue, operand values filled in from the CDB.
            always_ff @(posedge clk) begin
                if (wr) begin
                    tag_reg <= sq.issue_tag;
                    imm_reg <= sq.immed_in;
                    vj_reg  <= byp_j ? sq.cdb_data : sq.Vj_in;
                    vs_reg  <= byp_s ? sq.cdb_data : sq.Vstore_in;
                end else begin
                    if (hit_j) vj_reg <= sq.cdb_data;
                    if (hit_s) vs_reg <= sq.cdb_data;
                end
            end

            assign tag_arr[gi] = tag_reg;
            assign qj_arr[gi]  = qj_reg;
            assign qs_arr[gi]  = qs_reg;
            assign vj_arr[gi]  = vj_reg;
            assign vs_arr[gi]  = vs_reg;
            assign imm_arr[gi] = imm_reg;
        end
    endgenerate

    // Find the youngest live entry matching keep_tag; a head popping this cycle is excluded.
    always_comb begin
        keep_hit = 1'b0;
        keep_off = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PTR_W'(k) < count_int) && !(pop && (k == 0)) &&
                (tag_arr[head_idx + IDX_W'(k)] == sq.keep_tag)) begin
                keep_hit = 1'b1;
                keep_off = PTR_W'(k);
            end
        end
    end

    // Next pointers: flush rewinds the tail and overrides any issue.
    always_comb begin
        head_next = head_reg + PTR_W'(pop);
        if (sq.flush) begin
            tail_next = (sq.keep_en && keep_hit) ? (head_reg + keep_off + PTR_W'(1))
                                                 : head_next;
        end else begin
            tail_next = tail_reg + PTR_W'(issue_acc);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    assign head_addr   = vj_arr[head_idx] + {{16{imm_arr[head_idx][15]}}, imm_arr[head_idx]};
    assign unused_addr = ^head_addr;

    assign sq.full     = full_int;
    assign sq.count    = CNT_W'(count_int);
    assign sq.req_bus  = req_int;
    assign sq.addr_out = nonempty ? {tag_arr[head_idx], head_addr[31], head_addr[ADDR_W+1:2]}
                                  : '0;
    assign sq.data_out = nonempty ? {vj_arr[head_idx], tag_arr[head_idx], vs_arr[head_idx]}
                                  : '0;
endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_store_queue;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 5;
    localparam int ADDR_W = 23;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] vj;
        logic [4:0]  qj;
        logic [31:0] vs;
        logic [4:0]  qs;
        logic [15:0] imm;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    ent_t mq[$];

    always #5 clk = ~clk;

    store_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) sq_if ();

    store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq_if)
    );

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic m_ready();
        return (mq.size() > 0) && (mq[0].qj == 0) && (mq[0].qs == 0);
    endfunction

    function automatic logic [28:0] m_addr();
        logic [31:0] a;
        if (mq.size() == 0) return '0;
        a = mq[0].vj + {{16{mq[0].imm[15]}}, mq[0].imm};
        return {mq[0].tag, a[31], a[24:2]};
    endfunction

    function automatic logic [68:0] m_data();
        if (mq.size() == 0) return '0;
        return {mq[0].vj, mq[0].tag, mq[0].vs};
    endfunction

    task automatic check_model(input string name);
        chk({name, ".full"},  sq_if.full,     (mq.size() == DEPTH));
        chk({name, ".count"}, sq_if.count,    mq.size());
        chk({name, ".req"},   sq_if.req_bus,  m_ready());
        chk({name, ".addr"},  sq_if.addr_out, m_addr());
        chk({name, ".data"},  sq_if.data_out, m_data());
    endtask

    task automatic idle();
        sq_if.issue       = 1'b0;
        sq_if.flush       = 1'b0;
        sq_if.keep_en     = 1'b0;
        sq_if.keep_tag    = '0;
        sq_if.cdb_en      = 1'b0;
        sq_if.cdb_tag     = '0;
        sq_if.cdb_data    = '0;
        sq_if.bus_granted = 1'b0;
    endtask

    task automatic set_issue(input logic [4:0] tag, input logic [31:0] vj, input logic [4:0] qj,
                             input logic [31:0] vs, input logic [4:0] qs, input logic [15:0] imm);
        sq_if.issue     = 1'b1;
        sq_if.issue_tag = tag;
        sq_if.Vj_in     = vj;
        sq_if.Qj_in     = qj;
        sq_if.Vstore_in = vs;
        sq_if.Qstore_in = qs;
        sq_if.immed_in  = imm;
    endtask

    // Advance the reference model by one clock from the driven inputs, then clock the DUT.
    task automatic tick();
        logic pop, acc;
        ent_t ne;
        int   k;
        pop = sq_if.bus_granted && m_ready();
        acc = sq_if.issue && !sq_if.flush && (mq.size() < DEPTH);
        ne.tag = sq_if.issue_tag;
        ne.imm = sq_if.immed_in;
        ne.vj  = sq_if.Vj_in;
        ne.qj  = sq_if.Qj_in;
        ne.vs  = sq_if.Vstore_in;
        ne.qs  = sq_if.Qstore_in;
        if (sq_if.cdb_en && ne.qj != 0 && ne.qj == sq_if.cdb_tag) begin ne.vj = sq_if.cdb_data; ne.qj = 0; end
        if (sq_if.cdb_en && ne.qs != 0 && ne.qs == sq_if.cdb_tag) begin ne.vs = sq_if.cdb_data; ne.qs = 0; end
        if (sq_if.cdb_en) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].qj != 0 && mq[i].qj == sq_if.cdb_tag) begin mq[i].vj = sq_if.cdb_data; mq[i].qj = 0; end
                if (mq[i].qs != 0 && mq[i].qs == sq_if.cdb_tag) begin mq[i].vs = sq_if.cdb_data; mq[i].qs = 0; end
            end
        end
        if (pop) void'(mq.pop_front());
        if (sq_if.flush) begin
            k = -1;
            for (int i = 0; i < mq.size(); i++) if (mq[i].tag == sq_if.keep_tag) k = i;
            if (sq_if.keep_en && k >= 0) begin
                while (mq.size() > k + 1) void'(mq.pop_back());
            end else begin
                mq.delete();
            end
        end else if (acc) begin
            mq.push_back(ne);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        set_issue(0, 0, 0, 0, 0, 0);
        sq_if.issue = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_model("reset");
        chk("reset.addr0", sq_if.addr_out, 0);

        // Single ready store, latency and address formation
        set_issue(3, 32'h1000, 0, 32'hAB, 0, 16'hFFFC);
        tick(); idle();
        check_model("single");
        chk("single.req", sq_if.req_bus, 1);
        chk("single.addr", sq_if.addr_out, {5'd3, 1'b0, 23'h3FF});
        chk("single.data", sq_if.data_out, {32'h1000, 5'd3, 32'hAB});
        sq_if.bus_granted = 1'b1;
        tick(); idle();
        check_model("single_pop");

        // Program order: ready younger entry must wait for stalled head
        set_issue(1, 32'h2000, 0, 32'h0, 7, 16'h0008);
        tick();
        set_issue(2, 32'h3000, 0, 32'h77, 0, 16'h0000);
        tick(); idle();
        sq_if.bus_granted = 1'b1;
        repeat (2) begin
            tick();
            check_model("order_stall");
            chk("order.req_low", sq_if.req_bus, 0);
        end
        idle();
        sq_if.cdb_en = 1'b1; sq_if.cdb_tag = 7; sq_if.cdb_data = 32'h55;
        tick(); idle();
        check_model("order_cdb");
        chk("order.vstore", sq_if.data_out[31:0], 32'h55);
        chk("order.headtag", sq_if.addr_out[28:24], 1);
        sq_if.bus_granted = 1'b1;
        tick();
        check_model("order_pop1");
        chk("order.tag2", sq_if.addr_out[28:24], 2);
        tick(); idle();
        check_model("order_pop2");

        // Same-cycle CDB bypass on issue
        set_issue(4, 32'h0, 9, 32'h1, 0, 16'h0004);
        sq_if.cdb_en = 1'b1; sq_if.cdb_tag = 9; sq_if.cdb_data = 32'h20;
        tick(); idle();
        check_model("bypass");
        chk("bypass.req", sq_if.req_bus, 1);
        chk("bypass.vj", sq_if.data_out[68:37], 32'h20);
        sq_if.bus_granted = 1'b1;
        tick(); idle();

        // Fill to full, rejected issue, grant+issue when full
        for (int i = 0; i < DEPTH; i++) begin
            set_issue(5'(i + 1), 32'(i * 16), 0, 32'(i), 0, 16'h0);
            tick();
        end
        idle();
        check_model("fill");
        chk("fill.full", sq_if.full, 1);
        chk("fill.count", sq_if.count, 8);
        set_issue(20, 32'h0, 0, 32'h0, 0, 16'h0);
        tick();
        check_model("full_reject");
        chk("full_reject.count", sq_if.count, 8);
        set_issue(21, 32'h0, 0, 32'h0, 0, 16'h0);
        sq_if.bus_granted = 1'b1;
        tick(); idle();
        check_model("full_grant");
        chk("full_grant.count", sq_if.count, 7);
        set_issue(22, 32'h40, 0, 32'h5, 0, 16'h0);
        tick(); idle();
        check_model("refill");
        chk("refill.count", sq_if.count, 8);
        sq_if.flush = 1'b1;
        tick(); idle();
        check_model("flush_all");

        // Flush keeping up to tag 5; issue in the flush cycle is dropped
        for (int t = 4; t <= 7; t++) begin
            set_issue(5'(t), 32'(t * 256), 0, 32'(t), 0, 16'h0);
            tick();
        end
        idle();
        set_issue(9, 32'h0, 0, 32'h0, 0, 16'h0);
        sq_if.flush = 1'b1; sq_if.keep_en = 1'b1; sq_if.keep_tag = 5;
        tick(); idle();
        check_model("keep");
        chk("keep.count", sq_if.count, 2);
        chk("keep.tag4", sq_if.addr_out[28:24], 4);
        sq_if.bus_granted = 1'b1;
        tick(); idle();
        check_model("keep_pop");
        chk("keep.tag5", sq_if.addr_out[28:24], 5);
        sq_if.flush = 1'b1;
        tick(); idle();
        check_model("keep_none");
        chk("keep_none.count", sq_if.count, 0);

        // Asynchronous reset between edges with entries present
        for (int i = 0; i < 3; i++) begin
            set_issue(5'(10 + i), 32'h100, 0, 32'h9, 0, 16'h0);
            tick();
        end
        idle();
        #2;
        rst = 1'b1;
        sq_if.bus_granted = 1'b1;
        #1;
        mq.delete();
        check_model("async_rst");
        chk("async_rst.count", sq_if.count, 0);
        @(posedge clk);
        #1;
        check_model("rst_held");
        rst = 1'b0;
        idle();
        tick();
        check_model("rst_release");

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            idle();
            if ($urandom_range(99) < 60)
                set_issue(5'($urandom_range(31, 1)), $urandom,
                          ($urandom_range(1) != 0) ? 5'($urandom_range(6, 1)) : 5'd0,
                          $urandom,
                          ($urandom_range(1) != 0) ? 5'($urandom_range(6, 1)) : 5'd0,
                          16'($urandom));
            else
                sq_if.issue = 1'b0;
            if ($urandom_range(99) < 40) begin
                sq_if.cdb_en = 1'b1;
                sq_if.cdb_tag = 5'($urandom_range(6, 1));
                sq_if.cdb_data = $urandom;
            end
            sq_if.bus_granted = ($urandom_range(1) != 0);
            if ($urandom_range(99) < 4) begin
                sq_if.flush = 1'b1;
                sq_if.keep_en = ($urandom_range(1) != 0);
                if (mq.size() > 0 && $urandom_range(3) != 0)
                    sq_if.keep_tag = mq[$urandom_range(mq.size() - 1)].tag;
                else
                    sq_if.keep_tag = 5'($urandom_range(31));
            end
            tick();
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-002 Parameter DEPTH, 8, entry count; power of two, >=2.
REQ-003 Parameter TAG_W, 5, ROB tag width; tag 0 means "value ready".
REQ-004 Parameter ADDR_W, 23, word-address width on addr_out; <=30.
REQ-005 Ports (name direction width meaning):
 clk  in  1  clock
 rst  in  1  async active-high reset
 flush  in  1  mispredict unroll
 keep_en  in  1  retain entries up to keep_tag on flush
 keep_tag  in  TAG_W  ROB slot of youngest entry to retain (branch delay slot)
 issue  in  1  allocate entry at tail
 issue_tag  in  TAG_W  ROB slot of issued store
 immed_in  in  16  signed offset
 Vj_in  in  32  base value; Qj_in  in  TAG_W  base tag
 Vstore_in  in  32  store data; Qstore_in  in  TAG_W  data tag
 cdb_en  in  1  CDB valid; cdb_tag  in  TAG_W; cdb_data  in  32
 bus_granted  in  1  ROB accepts head entry this cycle
 full  out  1  no free entry
 count  out  $clog2(DEPTH+1)  valid entries
 req_bus  out  1  head entry valid and both operands ready
 addr_out  out  TAG_W+1+ADDR_W  {head tag, memio, word address}
 data_out  out  32+TAG_W+32  {head Vj, head tag, head Vstore}

Function
REQ-006 Entries SHALL form a circular FIFO; head/tail pointers log2(DEPTH)+1 bits, MSB distinguishes full from empty.
REQ-007 issue with full=0 SHALL write tail entry and advance tail next edge; issue with full=1 SHALL be ignored, no state change.
REQ-008 On issue, an operand whose Q_in equals cdb_tag with cdb_en=1 and Q_in!=0 SHALL be captured from cdb_data with Q=0 (same-cycle bypass).
REQ-009 Each cycle, every valid entry with Qj (or Qstore) nonzero and equal to cdb_tag with cdb_en=1 SHALL load cdb_data into Vj (or Vstore) and clear the tag.
REQ-010 req_bus SHALL be combinational from registered state: count!=0 and head Qj==0 and head Qstore==0; younger ready entries SHALL NOT bypass the head (stores leave in program order).
REQ-011 Address = Vj + sign-extended immed, 32-bit wrap; addr_out word field = address[ADDR_W+1:2], memio = address[31], tag field = head issue_tag.
REQ-012 bus_granted with req_bus=1 SHALL pop head next edge; bus_granted with req_bus=0 SHALL be ignored.
REQ-013 Issue and grant in same cycle SHALL both take effect; count unchanged; legal when full (pop frees the slot next cycle, issue still rejected this cycle).
REQ-014 flush SHALL override issue; grant in the flush cycle SHALL still pop head.
REQ-015 On flush with keep_en=1 and a valid entry (not being popped) whose tag==keep_tag, tail SHALL become that entry's index+1; all younger entries discarded, older retained.
REQ-016 On flush otherwise, tail SHALL equal post-pop head (queue empty).
REQ-017 Discarded entries SHALL NOT respond to CDB; full and count SHALL reflect new tail next cycle.
REQ-018 Latency: an issue with ready operands into an empty queue SHALL assert req_bus the following cycle.

Reset
REQ-019 rst SHALL asynchronously clear head, tail, all valid state and Q tags; full=0, count=0, req_bus=0, addr_out and data_out = 0.
REQ-020 rst mid-operation SHALL discard all entries; no grant is honoured while rst=1.

Verification
REQ-021 Issue tag 3, Vj=0x1000, immed=0xFFFC, Qj=Qstore=0, Vstore=0xAB -> next cycle req_bus=1, word addr=0x3FF, memio=0, data_out={0x1000,3,0xAB}.
REQ-022 Issue tags 1,2 with head Qstore=7, entry2 ready; CDB tag 7 data 0x55 -> entry2 not requested first; head req_bus=1 after CDB with Vstore=0x55.
REQ-023 Issue with Qj=9 while cdb_en=1, cdb_tag=9, data 0x20 -> entry captured ready, req_bus=1 next cycle.
REQ-024 Fill DEPTH=8 entries -> full=1, count=8; issue ignored; grant+issue same cycle -> count 7 then next issue accepted.
REQ-025 Entries tags 4,5,6,7, flush keep_en=1 keep_tag=5 -> count=2, tags 4,5 remain; keep_en=0 -> count=0.
REQ-026 rst asserted between clk edges with 3 entries -> outputs 0 immediately, count=0.
